uart_rx_param: RTL and testbench
================================

# uart_rx_param

Parametrised successor to the fixed 8N1 UART receiver. It is clocked by the 16x baud tick and supports 5–9 data bits, optional odd or even parity, and 1 or 2 stop bits. It adds an idle-arm qualifier, false-start rejection, and break detection, and reports framing and parity errors on separate outputs. It sits between the serial pad and the byte-level consumer.

## Interface
- P_DATA_BITS, 8: data bits per frame, legal 5..9.
- P_PARITY, 0: 0 = none, 1 = odd, 2 = even.
- P_STOP_BITS, 1: legal 1 or 2.
- P_IDLE_TH, 160: consecutive high x16_BAUD cycles required to arm the receiver, legal 16..4095.

Ports:
- x16_BAUD  in  1  clock at 16x baud rate.
- reset  in  1  asynchronous, active-high reset.
- serial_in  in  1  asynchronous serial line, idle high.
- Do  out  P_DATA_BITS  received data, LSB first on the line.
- valid  out  1  one-cycle pulse; frame complete.
- error  out  1  parity_err | frame_err | break_det.
- parity_err  out  1  parity mismatch on the last frame.
- frame_err  out  1  a stop bit was sampled low.
- break_det  out  1  all data, parity and stop samples were 0.
- busy  out  1  high in START, DATA, PARITY and STOP.

## Operation
- serial_in passes through a 2-flop synchronizer. All logic uses the synchronized value `rxs`.
- Bit counter `s` runs 0..15 within each bit window. Bit index counter `b` counts 0..P_DATA_BITS-1.
- Bit decision point is s=9. The decision value is defined under Configuration.
- States and transitions:
  - ARM: counts consecutive cycles of rxs=1. Counter clears on rxs=0. At P_IDLE_TH → IDLE.
  - IDLE: rxs=0 → START with s=0.
  - START: decision 1 → IDLE (false start, no output). Decision 0 → DATA at the next s=0.
  - DATA: each decision is shifted in LSB-first. After bit P_DATA_BITS-1 → PARITY if P_PARITY≠0, else → STOP.
  - PARITY: the decision is compared with the computed parity → STOP.
  - STOP: one window per stop bit. Any stop decision of 0 sets frame_err. At the last stop decision, update the outputs and pulse valid.
- After the last stop decision:
  - No frame error → IDLE immediately, without waiting for the rest of the stop window, so the receiver can resynchronize.
  - frame_err set → ARM.
- Do and the status flags update only with valid and hold until the next valid.
- A break is a frame_err with all samples 0. It sets break_det and Do=0, then ARM. Valid is still pulsed once.
- For P_DATA_BITS<9, the unused shift bits are not exported.
- Reset clears every output to 0 (Do=0, valid=0, all flags=0, busy=0) and enters ARM.
- Reset mid-frame discards the partial frame with no valid pulse.

## Timing
- Pin-to-`rxs` latency is 2 cycles.
- valid asserts (1 + P_DATA_BITS + (P_PARITY≠0) + P_STOP_BITS − 1)·16 + 10 cycles after the first cycle rxs=0 in IDLE.
  - 8N1: 154 cycles after the first low `rxs`, or 156 cycles from the pin edge.
- valid is high for exactly 1 cycle. There is no back-pressure: the consumer must capture Do in the valid cycle.
- An input low pulse shorter than 8 cycles never produces valid.
- Back-to-back frames with no idle gap are received without loss.

## Configuration
- UART_RX_MAJORITY_VOTE_EN defined: each decision is the 2-of-3 majority of rxs at s=7, 8 and 9. The decision is made at s=9.
- Not defined: each decision is rxs at s=8, registered and used at s=9. Decision timing and all latencies are identical in both builds.

## Structure
- Shared package `uart_pkg`: state enum (ARM, IDLE, START, DATA, PARITY, STOP), parity codes PAR_NONE/PAR_ODD/PAR_EVEN, and a function computing parity for a given width.
- Sub-module `uart_rx_sampler`: 2-flop synchronizer plus the s=7..9 sample registers and majority logic. It outputs `rxs` and `bit_val`.
- Top module: FSM, counters, shift register and output registers. Parameter legality is checked with elaboration-time assertions.

## Test plan
- 8N1 defaults; line high 200 cycles, then send 8'hA6 → Do=8'hA6, valid one cycle exactly 156 cycles after the start edge, error=0.
- P_PARITY=2; send 8'h5A with parity bit 1 (wrong) → valid, Do=8'h5A, parity_err=1, error=1. Send 8'h5A with parity 0 → parity_err=0.
- Low glitch of 5 cycles in IDLE → no valid, busy drops by cycle 12, next frame 8'h3C received correctly.
- Stop bit driven 0 with data 8'h81 → valid, frame_err=1. A frame started 100 cycles later is ignored. A frame after 160 high cycles is received.
- Line held low for 20 bit times → a single valid with break_det=1, Do=0, then no further valid until 160 high cycles have passed.
- Reset asserted at bit 4 of a frame → all outputs 0 asynchronously, no valid. After release plus 160 high cycles, 8'hFF is received.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ARM    = 3'd0,
        IDLE   = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } state_e;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_ODD  = 2'd1;
    localparam logic [1:0] PAR_EVEN = 2'd2;

    localparam int MAX_DATA_BITS = 9;

    // Expected parity bit over the low 'width' bits of data.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                        input int width,
                                        input logic [1:0] mode);
        logic x;
        x = 1'b0;
        for (int i = 0; i < MAX_DATA_BITS; i++) begin
            if (i < width) begin
                x = x ^ data[i];
            end
        end
        return (mode == PAR_ODD) ? ~x : x;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchronizer and per-bit sampling for uart_rx_param.
// Define UART_RX_MAJORITY_VOTE_EN for 2-of-3 voting over s=7,8,9.
module uart_rx_sampler
    import uart_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    input  logic [3:0] s_i,
    output logic       rxs_o,
    output logic       bit_val_o
);

    logic sync1_q;
    logic sync2_q;
    logic s8_q;

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic s7_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s7_q <= 1'b1;
        end else if (s_i == 4'd7) begin
            s7_q <= sync2_q;
        end
    end

    // The s=9 sample is the live synchronized value, so the vote resolves in the s=9 cycle.
    assign bit_val_o = (s7_q & s8_q) | (s7_q & sync2_q) | (s8_q & sync2_q);
`else
    assign bit_val_o = s8_q;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            s8_q    <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            if (s_i == 4'd8) begin
                s8_q <= sync2_q;
            end
        end
    end

    assign rxs_o = sync2_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver (5..9 data bits, none/odd/even parity, 1/2 stop bits), 16x clocked.
// Build option UART_RX_MAJORITY_VOTE_EN selects majority-vote bit decisions in uart_rx_sampler.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int P_DATA_BITS = 8,
    parameter int P_PARITY    = 0,
    parameter int P_STOP_BITS = 1,
    parameter int P_IDLE_TH   = 160
) (
    input  logic                   x16_BAUD,
    input  logic                   reset,
    input  logic                   serial_in,
    output logic [P_DATA_BITS-1:0] Do,
    output logic                   valid,
    output logic                   error,
    output logic                   parity_err,
    output logic                   frame_err,
    output logic                   break_det,
    output logic                   busy
);

    if (P_DATA_BITS < 5 || P_DATA_BITS > MAX_DATA_BITS) begin : g_bad_data_bits
        $error("uart_rx_param: P_DATA_BITS must be 5..9");
    end
    if (P_PARITY < 0 || P_PARITY > 2) begin : g_bad_parity
        $error("uart_rx_param: P_PARITY must be 0, 1 or 2");
    end
    if (P_STOP_BITS < 1 || P_STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_rx_param: P_STOP_BITS must be 1 or 2");
    end
    if (P_IDLE_TH < 16 || P_IDLE_TH > 4095) begin : g_bad_idle_th
        $error("uart_rx_param: P_IDLE_TH must be 16..4095");
    end

    logic                   rxs;
    logic                   bit_val;
    state_e                 state_q;
    logic [3:0]             s_q;
    logic [3:0]             b_q;
    logic [11:0]            arm_cnt_q;
    logic [P_DATA_BITS-1:0] shift_q;
    logic                   par_err_q;
    logic                   ferr_q;
    logic                   zero_q;

    logic dec;
    logic exp_par;
    logic stop_ferr;
    logic stop_zero;

    uart_rx_sampler u_sampler (
        .clk_i     (x16_BAUD),
        .rst_i     (reset),
        .rx_i      (serial_in),
        .s_i       (s_q),
        .rxs_o     (rxs),
        .bit_val_o (bit_val)
    );

    assign dec       = (s_q == 4'd9);
    assign exp_par   = parity_bit(9'(shift_q), P_DATA_BITS, 2'(P_PARITY));
    assign stop_ferr = ferr_q | ~bit_val;
    assign stop_zero = zero_q & ~bit_val;

    // Data shift register carries no reset; it is only consumed after a full frame.
    always_ff @(posedge x16_BAUD) begin
        if (state_q == DATA && dec) begin
            shift_q <= {bit_val, shift_q[P_DATA_BITS-1:1]};
        end
    end

    always_ff @(posedge x16_BAUD or posedge reset) begin
        if (reset) begin
            state_q    <= ARM;
            s_q        <= 4'd0;
            b_q        <= 4'd0;
            arm_cnt_q  <= 12'd0;
            par_err_q  <= 1'b0;
            ferr_q     <= 1'b0;
            zero_q     <= 1'b0;
            Do         <= '0;
            valid      <= 1'b0;
            error      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state_q)
                ARM: begin
                    s_q <= 4'd0;
                    if (!rxs) begin
                        arm_cnt_q <= 12'd0;
                    end else if (arm_cnt_q == 12'(P_IDLE_TH - 1)) begin
                        arm_cnt_q <= 12'd0;
                        state_q   <= IDLE;
                    end else begin
                        arm_cnt_q <= arm_cnt_q + 12'd1;
                    end
                end
                IDLE: begin
                    // The cycle that first sees the low line counts as s=0 of the start bit.
                    if (!rxs) begin
                        state_q <= START;
                        s_q     <= 4'd1;
                        busy    <= 1'b1;
                    end else begin
                        s_q <= 4'd0;
                    end
                end
                START: begin
                    s_q <= s_q + 4'd1;
                    if (dec) begin
                        if (bit_val) begin
                            state_q <= IDLE;
                            s_q     <= 4'd0;
                            busy    <= 1'b0;
                        end else begin
                            state_q   <= DATA;
                            b_q       <= 4'd0;
                            zero_q    <= 1'b1;
                            par_err_q <= 1'b0;
                            ferr_q    <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    s_q <= s_q + 4'd1;
                    if (dec) begin
                        zero_q <= zero_q & ~bit_val;
                        if (b_q == 4'(P_DATA_BITS - 1)) begin
                            b_q     <= 4'd0;
                            state_q <= (P_PARITY != 0) ? PARITY : STOP;
                        end else begin
                            b_q <= b_q + 4'd1;
                        end
                    end
                end
                PARITY: begin
                    s_q <= s_q + 4'd1;
                    if (dec) begin
                        par_err_q <= (bit_val != exp_par);
                        zero_q    <= zero_q & ~bit_val;
                        state_q   <= STOP;
                    end
                end
                STOP: begin
                    s_q <= s_q + 4'd1;
                    if (dec) begin
                        if (b_q == 4'(P_STOP_BITS - 1)) begin
                            valid      <= 1'b1;
                            Do         <= stop_zero ? '0 : shift_q;
                            parity_err <= par_err_q;
                            frame_err  <= stop_ferr;
                            break_det  <= stop_ferr & stop_zero;
                            error      <= par_err_q | stop_ferr;
                            busy       <= 1'b0;
                            s_q        <= 4'd0;
                            b_q        <= 4'd0;
                            arm_cnt_q  <= 12'd0;
                            // A clean frame resynchronizes at once; a bad one must see idle again.
                            state_q    <= stop_ferr ? ARM : IDLE;
                        end else begin
                            b_q    <= b_q + 4'd1;
                            ferr_q <= stop_ferr;
                            zero_q <= stop_zero;
                        end
                    end
                end
                default: begin
                    state_q <= ARM;
                    s_q     <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8N1 default instance and an even-parity instance.
module tb_uart_rx_param;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] ser;

    logic [7:0] Do0, Do1;
    logic       valid0, error0, perr0, ferr0, brk0, busy0;
    logic       valid1, error1, perr1, ferr1, brk1, busy1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vh0 = 0, vh1 = 0;
    int vc0 = 0, vc1 = 0;
    int t_start = 0;

    uart_rx_param dut0 (
        .x16_BAUD   (clk),
        .reset      (reset),
        .serial_in  (ser[0]),
        .Do         (Do0),
        .valid      (valid0),
        .error      (error0),
        .parity_err (perr0),
        .frame_err  (ferr0),
        .break_det  (brk0),
        .busy       (busy0)
    );

    uart_rx_param #(.P_PARITY(2)) dut1 (
        .x16_BAUD   (clk),
        .reset      (reset),
        .serial_in  (ser[1]),
        .Do         (Do1),
        .valid      (valid1),
        .error      (error1),
        .parity_err (perr1),
        .frame_err  (ferr1),
        .break_det  (brk1),
        .busy       (busy1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Count valid-high cycles and remember when the last one was seen.
    always @(negedge clk) begin
        if (valid0 === 1'b1) begin
            vh0 <= vh0 + 1;
            vc0 <= cyc;
        end
        if (valid1 === 1'b1) begin
            vh1 <= vh1 + 1;
            vc1 <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at a negedge with the line high again.
    task automatic send(input int ch, input logic [8:0] d, input int n,
                        input int has_par, input logic pbit, input logic stopv);
        ser[ch] = 1'b0;
        t_start = cyc;
        repeat (16) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            ser[ch] = d[i];
            repeat (16) @(negedge clk);
        end
        if (has_par != 0) begin
            ser[ch] = pbit;
            repeat (16) @(negedge clk);
        end
        ser[ch] = stopv;
        repeat (16) @(negedge clk);
        ser[ch] = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        ser   = 2'b11;
        repeat (3) @(negedge clk);
        check("rst_flags0", {valid0, error0, perr0, ferr0, brk0, busy0}, 0);
        check("rst_do0", Do0, 0);
        check("rst_flags1", {valid1, error1, perr1, ferr1, brk1, busy1}, 0);
        reset = 1'b0;
        idle(200);

        send(0, 9'h0A6, 8, 0, 1'b0, 1'b1);
        check("a6_do", Do0, 8'hA6);
        check("a6_err", {error0, perr0, ferr0, brk0}, 0);
        check("a6_lat", vc0 - t_start, 156);
        check("a6_cnt", vh0, 1);

        send(1, 9'h05A, 8, 1, 1'b1, 1'b1);
        check("par_bad_do", Do1, 8'h5A);
        check("par_bad_perr", perr1, 1);
        check("par_bad_err", error1, 1);
        check("par_lat", vc1 - t_start, 172);
        check("par_bad_cnt", vh1, 1);
        send(1, 9'h05A, 8, 1, 1'b0, 1'b1);
        check("par_ok_perr", {perr1, error1, ferr1}, 0);
        check("par_ok_cnt", vh1, 2);

        idle(20);
        ser[0] = 1'b0;
        t_start = cyc;
        idle(4);
        check("glitch_busy", busy0, 1);
        idle(1);
        ser[0] = 1'b1;
        idle(7);
        check("glitch_busy_drop", busy0, 0);
        idle(20);
        check("glitch_cnt", vh0, 1);
        send(0, 9'h03C, 8, 0, 1'b0, 1'b1);
        check("3c_do", Do0, 8'h3C);
        check("3c_cnt", vh0, 2);

        send(0, 9'h012, 8, 0, 1'b0, 1'b1);
        check("b2b_first", Do0, 8'h12);
        send(0, 9'h034, 8, 0, 1'b0, 1'b1);
        check("b2b_second", Do0, 8'h34);
        check("b2b_cnt", vh0, 4);

        idle(20);
        send(0, 9'h081, 8, 0, 1'b0, 1'b0);
        check("ferr_do", Do0, 8'h81);
        check("ferr_flags", {error0, perr0, ferr0, brk0}, 4'b1010);
        check("ferr_cnt", vh0, 5);
        idle(100);
        send(0, 9'h055, 8, 0, 1'b0, 1'b1);
        check("ferr_ignored", vh0, 5);
        idle(200);
        send(0, 9'h0C3, 8, 0, 1'b0, 1'b1);
        check("ferr_recover_do", Do0, 8'hC3);
        check("ferr_recover_flags", {error0, ferr0}, 0);
        check("ferr_recover_cnt", vh0, 6);

        ser[0] = 1'b0;
        idle(320);
        ser[0] = 1'b1;
        check("brk_cnt", vh0, 7);
        check("brk_flags", {error0, perr0, ferr0, brk0}, 4'b1011);
        check("brk_do", Do0, 0);
        idle(100);
        send(0, 9'h00F, 8, 0, 1'b0, 1'b1);
        check("brk_ignored", vh0, 7);
        idle(200);
        send(0, 9'h099, 8, 0, 1'b0, 1'b1);
        check("brk_recover_do", Do0, 8'h99);
        check("brk_recover_flags", {error0, brk0}, 0);
        check("brk_recover_cnt", vh0, 8);

        ser[0] = 1'b0;
        idle(16);
        ser[0] = 1'b1;
        idle(72);
        check("rst_mid_busy", busy0, 1);
        reset = 1'b1;
        #1;
        check("rst_mid_flags", {valid0, error0, perr0, ferr0, brk0, busy0}, 0);
        check("rst_mid_do", Do0, 0);
        idle(3);
        reset = 1'b0;
        idle(200);
        check("rst_mid_no_valid", vh0, 8);
        send(0, 9'h0FF, 8, 0, 1'b0, 1'b1);
        check("ff_do", Do0, 8'hFF);
        check("ff_cnt", vh0, 9);
        check("ff_err", error0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
